// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event block: lane state encoding,
// unit constants and a width helper that never returns zero.
package btn_evt_pkg;

    typedef enum logic [1:0] {
        BE_IDLE,
        BE_DELAY,
        BE_REPEAT
    } be_state_t;

    localparam int MS_PER_S = 1000;

    // Counter width for 'value' states, at least one bit so degenerate configs still elaborate.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/button_events_if.sv
// Button lane bundle between the debouncer side (master) and the event
// converter (slave): debounced levels in, event pulses and held levels out.
interface button_events_if #(
    parameter int N = 6
);
    logic [N-1:0] pbtn_db;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] repeat_pulse;
    logic [N-1:0] held;

    modport master (
        output pbtn_db,
        input  press_pulse,
        input  release_pulse,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  pbtn_db,
        output press_pulse,
        output release_pulse,
        output repeat_pulse,
        output held
    );
endinterface

// File: rtl/button_events_ms_tick_gen.sv
// Millisecond prescaler shared by all button lanes: counts 0..TICK_TOP and
// flags the top count for exactly one clock.
module ms_tick_gen
    import btn_evt_pkg::*;
#(
    parameter int TICK_TOP = 49_999
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int CNT_W = clog2_min1(TICK_TOP + 1);
    localparam logic [CNT_W-1:0] TOP = CNT_W'(TICK_TOP);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt == TOP) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == TOP);
endmodule

// File: rtl/button_events.sv
// Turns debounced button levels into one-clock press/release/repeat pulses.
// Auto-repeat is built only when BUTTON_EVENTS_AUTOREPEAT_EN is defined.
module button_events
    import btn_evt_pkg::*;
#(
    parameter int NUM_BUTTONS       = 6,
    parameter int CLK_FREQUENCY_HZ  = 50_000_000,
    parameter int REPEAT_DELAY_MS   = 400,
    parameter int REPEAT_RATE_HZ    = 10,
    parameter int SIMULATE          = 0,
    parameter int SIMULATE_TICK_CNT = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    button_events_if.slave bus
);
    if (REPEAT_DELAY_MS < 1 || REPEAT_RATE_HZ < 1 || REPEAT_RATE_HZ > MS_PER_S ||
        CLK_FREQUENCY_HZ < MS_PER_S || (SIMULATE != 0 && SIMULATE_TICK_CNT < 1)) begin : g_cfg_err
        $error("button_events: invalid configuration");
    end

    logic                   primed;
    logic [NUM_BUTTONS-1:0] prev_q;
    logic [NUM_BUTTONS-1:0] rise, fall;
    logic [NUM_BUTTONS-1:0] press_v, release_v, repeat_v;

    // The first clock after reset only captures the levels, so a button held
    // through reset never produces a spurious press or release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            primed <= 1'b0;
            prev_q <= '0;
        end else begin
            primed <= 1'b1;
            prev_q <= bus.pbtn_db;
        end
    end

    assign rise = bus.pbtn_db & ~prev_q;
    assign fall = ~bus.pbtn_db & prev_q;

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
    localparam int TICK_TOP   = (SIMULATE != 0) ? SIMULATE_TICK_CNT : CLK_FREQUENCY_HZ / MS_PER_S - 1;
    localparam int DELAY_T    = REPEAT_DELAY_MS;
    localparam int PERIOD_RAW = (REPEAT_RATE_HZ < 1) ? 1 : MS_PER_S / REPEAT_RATE_HZ;
    localparam int PERIOD_T   = (PERIOD_RAW < 1) ? 1 : PERIOD_RAW;
    localparam int CNT_W      = clog2_min1((DELAY_T > PERIOD_T) ? DELAY_T : PERIOD_T);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_T - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_T - 1);

    logic ms_tick;

    ms_tick_gen #(.TICK_TOP(TICK_TOP)) u_ms_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (ms_tick)
    );
`endif

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_lane
        logic press_r, release_r;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
        be_state_t        state;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_last;
        logic             repeat_r;

        assign cnt_last = (state == BE_DELAY) ? DELAY_LAST : PERIOD_LAST;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state     <= BE_IDLE;
                cnt       <= '0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                repeat_r  <= 1'b0;
            end else begin
                // NOTE: pulses default low with non-blocking writes here; any later
                // assignment in this block wins, giving exactly one-clock pulses.
                press_r   <= 1'b0;
                release_r <= 1'b0;
                repeat_r  <= 1'b0;
                if (primed) begin
                    case (state)
                        BE_IDLE: begin
                            if (rise[i]) begin
                                state    <= BE_DELAY;
                                cnt      <= '0;
                                press_r  <= 1'b1;
                                repeat_r <= 1'b1;
                            end
                        end
                        BE_DELAY, BE_REPEAT: begin
                            // A release always beats a coincident repeat.
                            if (fall[i]) begin
                                state     <= BE_IDLE;
                                release_r <= 1'b1;
                            end else if (ms_tick) begin
                                if (cnt == cnt_last) begin
                                    state    <= BE_REPEAT;
                                    cnt      <= '0;
                                    repeat_r <= 1'b1;
                                end else begin
                                    cnt <= cnt + CNT_W'(1);
                                end
                            end
                        end
                        default: state <= BE_IDLE;
                    endcase
                end
            end
        end

        assign repeat_v[i] = repeat_r;
`else
        logic active;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                active    <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
                if (primed) begin
                    if (!active && rise[i]) begin
                        active  <= 1'b1;
                        press_r <= 1'b1;
                    end else if (active && fall[i]) begin
                        active    <= 1'b0;
                        release_r <= 1'b1;
                    end
                end
            end
        end

        assign repeat_v[i] = press_r;
`endif
        assign press_v[i]   = press_r;
        assign release_v[i] = release_r;
    end

    assign bus.press_pulse   = press_v;
    assign bus.release_pulse = release_v;
    assign bus.repeat_pulse  = repeat_v;
    assign bus.held          = prev_q;
endmodule
